// File: rtl/alu_exec_unit.sv
// Execute stage: ALU control decode, integer ALU with HI/LO registers and branch resolution.
// Optional signed-overflow detection is built when ALU_OVERFLOW_EN is defined.
module alu_exec_unit #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [3:0]   alu_op_i,
  input  logic [5:0]   funct_i,
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         branch_i,
  input  logic [2:0]   branch_op_i,
  input  logic [W-1:0] br_a_i,
  input  logic [W-1:0] br_b_i,
  output logic [3:0]   alu_ctl_o,
  output logic         hilo_enable_o,
  output logic         shift_o,
  output logic [W-1:0] result_o,
  output logic         zero_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o,
  output logic         branch_taken_o,
  output logic         ovf_o
);

  localparam logic [3:0] CtlAnd   = 4'b0000;
  localparam logic [3:0] CtlOr    = 4'b0001;
  localparam logic [3:0] CtlAdd   = 4'b0010;
  localparam logic [3:0] CtlXor   = 4'b0011;
  localparam logic [3:0] CtlSll   = 4'b0100;
  localparam logic [3:0] CtlSrl   = 4'b0101;
  localparam logic [3:0] CtlSub   = 4'b0110;
  localparam logic [3:0] CtlSlt   = 4'b0111;
  localparam logic [3:0] CtlSltu  = 4'b1000;
  localparam logic [3:0] CtlSra   = 4'b1001;
  localparam logic [3:0] CtlMult  = 4'b1010;
  localparam logic [3:0] CtlMultu = 4'b1011;
  localparam logic [3:0] CtlNor   = 4'b1100;
  localparam logic [3:0] CtlMfhi  = 4'b1101;
  localparam logic [3:0] CtlMflo  = 4'b1110;
  localparam logic [3:0] CtlPassb = 4'b1111;

  logic [3:0]     alu_ctl;
  logic           hilo_enable;
  logic           shift;
  logic [W-1:0]   hi_q, lo_q;
  logic [W-1:0]   hi_d, lo_d;
  logic [W-1:0]   result;
  logic [2*W-1:0] prod_s, prod_u;
  logic [4:0]     shamt;
  logic           br_eq, br_gt, br_cond;

  always_comb begin
    alu_ctl     = CtlAdd;
    hilo_enable = 1'b0;
    shift       = 1'b0;
    case (alu_op_i)
      4'b0000: alu_ctl = CtlAdd;
      4'b0001: alu_ctl = CtlSub;
      4'b0011: alu_ctl = CtlAnd;
      4'b0100: alu_ctl = CtlOr;
      4'b0101: alu_ctl = CtlXor;
      4'b0110: alu_ctl = CtlSlt;
      4'b0111: alu_ctl = CtlPassb;
      4'b0010: begin
        case (funct_i)
          6'b100000, 6'b100001: alu_ctl = CtlAdd;
          6'b100010, 6'b100011: alu_ctl = CtlSub;
          6'b100100: alu_ctl = CtlAnd;
          6'b100101: alu_ctl = CtlOr;
          6'b100110: alu_ctl = CtlXor;
          6'b100111: alu_ctl = CtlNor;
          6'b101010: alu_ctl = CtlSlt;
          6'b101011: alu_ctl = CtlSltu;
          6'b010000: alu_ctl = CtlMfhi;
          6'b010010: alu_ctl = CtlMflo;
          6'b000000: begin alu_ctl = CtlSll; shift = 1'b1; end
          6'b000010: begin alu_ctl = CtlSrl; shift = 1'b1; end
          6'b000011: begin alu_ctl = CtlSra; shift = 1'b1; end
          6'b011000: begin alu_ctl = CtlMult;  hilo_enable = 1'b1; end
          6'b011001: begin alu_ctl = CtlMultu; hilo_enable = 1'b1; end
          default:   alu_ctl = CtlAdd;
        endcase
      end
      default: alu_ctl = CtlAdd;
    endcase
  end

  // Operands are widened before multiplying so the full 2W-bit product is kept.
  assign prod_s = {{W{a_i[W-1]}}, a_i} * {{W{b_i[W-1]}}, b_i};
  assign prod_u = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
  assign shamt  = b_i[4:0];

  always_comb begin
    result = '0;
    case (alu_ctl)
      CtlAnd:   result = a_i & b_i;
      CtlOr:    result = a_i | b_i;
      CtlAdd:   result = a_i + b_i;
      CtlXor:   result = a_i ^ b_i;
      CtlSll:   result = a_i << shamt;
      CtlSrl:   result = a_i >> shamt;
      CtlSub:   result = a_i - b_i;
      CtlSlt:   result = {{(W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      CtlSltu:  result = {{(W-1){1'b0}}, a_i < b_i};
      CtlSra:   result = $unsigned($signed(a_i) >>> shamt);
      CtlMult:  result = prod_s[W-1:0];
      CtlMultu: result = prod_u[W-1:0];
      CtlNor:   result = ~(a_i | b_i);
      CtlMfhi:  result = hi_q;
      CtlMflo:  result = lo_q;
      CtlPassb: result = b_i;
      default:  result = '0;
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (en_i && alu_ctl == CtlMult) begin
      {hi_d, lo_d} = prod_s;
    end else if (en_i && alu_ctl == CtlMultu) begin
      {hi_d, lo_d} = prod_u;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf;
  always_comb begin
    ovf = 1'b0;
    if (alu_ctl == CtlAdd) begin
      ovf = (a_i[W-1] == b_i[W-1]) && (result[W-1] != a_i[W-1]);
    end else if (alu_ctl == CtlSub) begin
      ovf = (a_i[W-1] != b_i[W-1]) && (result[W-1] != a_i[W-1]);
    end
  end
  assign ovf_o = ovf;
`else
  assign ovf_o = 1'b0;
`endif

  assign br_eq = (br_a_i == br_b_i);
  assign br_gt = (br_a_i > br_b_i);

  always_comb begin
    br_cond = 1'b0;
    case (branch_op_i)
      3'b000:  br_cond = br_eq;
      3'b001:  br_cond = !br_eq;
      3'b010:  br_cond = br_gt;
      3'b011:  br_cond = br_gt | br_eq;
      3'b100:  br_cond = !br_gt & !br_eq;
      3'b101:  br_cond = !br_gt;
      default: br_cond = 1'b0;
    endcase
  end

  assign alu_ctl_o      = alu_ctl;
  assign hilo_enable_o  = hilo_enable;
  assign shift_o        = shift;
  assign result_o       = result;
  assign zero_o         = (result == '0);
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;
  assign branch_taken_o = branch_i & br_cond;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   alu_op;
  logic [5:0]   funct;
  logic         en;
  logic [W-1:0] a, b;
  logic         branch;
  logic [2:0]   branch_op;
  logic [W-1:0] br_a, br_b;
  logic [3:0]   alu_ctl;
  logic         hilo_enable, shift, zero, branch_taken, ovf;
  logic [W-1:0] result, hi, lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.W(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .alu_op_i(alu_op), .funct_i(funct), .en_i(en),
    .a_i(a), .b_i(b), .branch_i(branch), .branch_op_i(branch_op), .br_a_i(br_a),
    .br_b_i(br_b), .alu_ctl_o(alu_ctl), .hilo_enable_o(hilo_enable), .shift_o(shift),
    .result_o(result), .zero_o(zero), .hi_o(hi), .lo_o(lo),
    .branch_taken_o(branch_taken), .ovf_o(ovf)
  );

  task automatic drive(input logic [3:0] op, input logic [5:0] fn,
                       input logic [W-1:0] va, input logic [W-1:0] vb);
    alu_op = op; funct = fn; a = va; b = vb;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; branch = 1'b0; branch_op = 3'b000; br_a = '0; br_b = '0;
    drive(4'b0010, 6'b011000, 32'd5, 32'd6);
    @(posedge clk); #1;
    tests++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      fails++; $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", hi, lo);
    end
    tests++;
    if (result !== 32'd30) begin
      fails++; $display("FAIL reset_comb: result=%h expected %h", result, 32'd30);
    end
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_rtype;
    drive(4'b0010, 6'b100010, 32'd5, 32'd7);
    tests++;
    if (alu_ctl !== 4'b0110 || result !== 32'hFFFFFFFE || zero !== 1'b0 ||
        shift !== 1'b0 || hilo_enable !== 1'b0) begin
      fails++;
      $display("FAIL rtype_sub: ctl=%b res=%h z=%b sh=%b he=%b expected 0110 fffffffe 0 0 0",
               alu_ctl, result, zero, shift, hilo_enable);
    end
    drive(4'b0010, 6'b100011, 32'd9, 32'd9);
    tests++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      fails++; $display("FAIL rtype_zero: res=%h z=%b expected 0 1", result, zero);
    end
    drive(4'b0010, 6'b100111, 32'h0, 32'hF0F0F0F0);
    tests++;
    if (alu_ctl !== 4'b1100 || result !== 32'h0F0F0F0F) begin
      fails++; $display("FAIL rtype_nor: ctl=%b res=%h expected 1100 0f0f0f0f", alu_ctl, result);
    end
    drive(4'b0010, 6'b111111, 32'd2, 32'd3);
    tests++;
    if (alu_ctl !== 4'b0010 || result !== 32'd5 || shift !== 1'b0 || hilo_enable !== 1'b0) begin
      fails++; $display("FAIL rtype_unknown: ctl=%b res=%h sh=%b he=%b expected 0010 5 0 0",
                        alu_ctl, result, shift, hilo_enable);
    end
  endtask

  task automatic test_aluop_decode;
    drive(4'b0111, 6'b000000, 32'h12345678, 32'hCAFEF00D);
    tests++;
    if (alu_ctl !== 4'b1111 || result !== 32'hCAFEF00D || shift !== 1'b0) begin
      fails++; $display("FAIL aluop_passb: ctl=%b res=%h sh=%b expected 1111 cafef00d 0",
                        alu_ctl, result, shift);
    end
    drive(4'b0001, 6'b011000, 32'd10, 32'd3);
    tests++;
    if (alu_ctl !== 4'b0110 || result !== 32'd7 || hilo_enable !== 1'b0) begin
      fails++; $display("FAIL aluop_sub: ctl=%b res=%h he=%b expected 0110 7 0",
                        alu_ctl, result, hilo_enable);
    end
    drive(4'b1000, 6'b100010, 32'd10, 32'd3);
    tests++;
    if (alu_ctl !== 4'b0010 || result !== 32'd13) begin
      fails++; $display("FAIL aluop_other: ctl=%b res=%h expected 0010 d", alu_ctl, result);
    end
    drive(4'b0101, 6'b000000, 32'hFF00FF00, 32'h0F0F0F0F);
    tests++;
    if (alu_ctl !== 4'b0011 || result !== 32'hF00FF00F) begin
      fails++; $display("FAIL aluop_xor: ctl=%b res=%h expected 0011 f00ff00f", alu_ctl, result);
    end
  endtask

  task automatic test_shift_compare;
    drive(4'b0010, 6'b000011, 32'h80000000, 32'd4);
    tests++;
    if (shift !== 1'b1 || alu_ctl !== 4'b1001 || result !== 32'hF8000000) begin
      fails++; $display("FAIL sra: sh=%b ctl=%b res=%h expected 1 1001 f8000000",
                        shift, alu_ctl, result);
    end
    drive(4'b0010, 6'b000010, 32'h80000000, 32'd4);
    tests++;
    if (result !== 32'h08000000) begin
      fails++; $display("FAIL srl: res=%h expected 08000000", result);
    end
    drive(4'b0010, 6'b000000, 32'h1, 32'h00000023);
    tests++;
    if (result !== 32'h8 || shift !== 1'b1) begin
      fails++; $display("FAIL sll_masked: res=%h sh=%b expected 8 1", result, shift);
    end
    drive(4'b0010, 6'b101010, 32'hFFFFFFFF, 32'd1);
    tests++;
    if (result !== 32'd1) begin
      fails++; $display("FAIL slt: res=%h expected 1", result);
    end
    drive(4'b0010, 6'b101011, 32'hFFFFFFFF, 32'd1);
    tests++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      fails++; $display("FAIL sltu: res=%h z=%b expected 0 1", result, zero);
    end
  endtask

  task automatic test_multiply;
    @(negedge clk);
    en = 1'b1;
    drive(4'b0010, 6'b011000, 32'hFFFFFFFE, 32'd3);
    tests++;
    if (hilo_enable !== 1'b1 || alu_ctl !== 4'b1010 || result !== 32'hFFFFFFFA) begin
      fails++; $display("FAIL mult_comb: he=%b ctl=%b res=%h expected 1 1010 fffffffa",
                        hilo_enable, alu_ctl, result);
    end
    @(posedge clk); #1;
    tests++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      fails++; $display("FAIL mult_hilo: hi=%h lo=%h expected ffffffff fffffffa", hi, lo);
    end
    @(negedge clk);
    drive(4'b0010, 6'b010010, 32'd0, 32'd0);
    tests++;
    if (result !== 32'hFFFFFFFA) begin
      fails++; $display("FAIL mflo: res=%h expected fffffffa", result);
    end
    drive(4'b0010, 6'b010000, 32'd0, 32'd0);
    tests++;
    if (result !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL mfhi: res=%h expected ffffffff", result);
    end
    en = 1'b0;
    drive(4'b0010, 6'b011001, 32'd5, 32'd7);
    @(posedge clk); #1;
    tests++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      fails++; $display("FAIL multu_noen: hi=%h lo=%h expected ffffffff fffffffa", hi, lo);
    end
    @(negedge clk);
    en = 1'b1;
    drive(4'b0010, 6'b011001, 32'hFFFFFFFF, 32'd2);
    @(posedge clk); #1;
    tests++;
    if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin
      fails++; $display("FAIL multu_hilo: hi=%h lo=%h expected 1 fffffffe", hi, lo);
    end
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      fails++; $display("FAIL async_reset: hi=%h lo=%h expected 0/0", hi, lo);
    end
    en = 1'b1;
    drive(4'b0010, 6'b011000, 32'd7, 32'd7);
    @(posedge clk); #1;
    tests++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      fails++; $display("FAIL reset_over_mult: hi=%h lo=%h expected 0/0", hi, lo);
    end
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_branch;
    logic [2:0] ops [8];
    logic       exp_t [8];
    ops   = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b010, 3'b100, 3'b110, 3'b111};
    exp_t = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0};
    branch = 1'b1; br_a = 32'd9; br_b = 32'd9;
    for (int i = 0; i < 8; i++) begin
      branch_op = ops[i];
      #1;
      tests++;
      if (branch_taken !== exp_t[i]) begin
        fails++; $display("FAIL branch_eq op=%b: taken=%b expected %b",
                          ops[i], branch_taken, exp_t[i]);
      end
    end
    br_a = 32'd3; br_b = 32'd9;
    ops   = '{3'b100, 3'b101, 3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
    exp_t = '{1'b1,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0};
    for (int i = 0; i < 8; i++) begin
      branch_op = ops[i];
      #1;
      tests++;
      if (branch_taken !== exp_t[i]) begin
        fails++; $display("FAIL branch_lt op=%b: taken=%b expected %b",
                          ops[i], branch_taken, exp_t[i]);
      end
    end
    br_a = 32'hFFFFFFFF; br_b = 32'd1; branch_op = 3'b010;
    #1;
    tests++;
    if (branch_taken !== 1'b1) begin
      fails++; $display("FAIL branch_gt_unsigned: taken=%b expected 1", branch_taken);
    end
    branch = 1'b0;
    br_a = 32'd3; br_b = 32'd9;
    for (int i = 0; i < 8; i++) begin
      branch_op = 3'(i);
      #1;
      tests++;
      if (branch_taken !== 1'b0) begin
        fails++; $display("FAIL branch_off op=%0d: taken=%b expected 0", i, branch_taken);
      end
    end
  endtask

  task automatic test_overflow;
    logic exp_ovf;
`ifdef ALU_OVERFLOW_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    drive(4'b0000, 6'b000000, 32'h7FFFFFFF, 32'd1);
    tests++;
    if (result !== 32'h80000000 || ovf !== exp_ovf) begin
      fails++; $display("FAIL ovf_add: res=%h ovf=%b expected 80000000 %b", result, ovf, exp_ovf);
    end
    drive(4'b0001, 6'b000000, 32'h80000000, 32'd1);
    tests++;
    if (result !== 32'h7FFFFFFF || ovf !== exp_ovf) begin
      fails++; $display("FAIL ovf_sub: res=%h ovf=%b expected 7fffffff %b", result, ovf, exp_ovf);
    end
    drive(4'b0000, 6'b000000, 32'd1, 32'd2);
    tests++;
    if (ovf !== 1'b0) begin
      fails++; $display("FAIL ovf_none: ovf=%b expected 0", ovf);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_aluop_decode();
    test_shift_compare();
    test_multiply();
    test_async_reset();
    test_branch();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Combined execute-stage block of the pipelined MIPS-style processor: ALU control decode, integer ALU with HI/LO registers, and branch resolution.
- ALU control decode maps AluOp and funct to an ALU control code plus hilo/shift flags.
- Branch resolution compares two ID-stage operands and produces the taken signal that drives the PC and the IF/ID flush.
- Only state: the HI/LO register pair. Everything else is combinational.

Parameters:
- W, 32, datapath width; product is 2*W bits.

Ports:
- clk  in  1  clock; HI/LO update on rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_op  in  4  AluOp from ControlUnit.
- funct  in  6  instr[5:0].
- en  in  1  HI/LO write qualifier; low during stall or bubble.
- a  in  W  operand A (rs after forwarding).
- b  in  W  operand B (rt, immediate or shamt after muxing).
- branch  in  1  Branch from ControlUnit.
- branch_op  in  3  BranchOp.
- br_a  in  W  ID-stage rs value.
- br_b  in  W  ID-stage rt value.
- alu_ctl  out  4  decoded control code.
- hilo_enable  out  1  instruction targets HI/LO; suppresses the register-file write.
- shift  out  1  funct is a shift; B mux selects shamt.
- result  out  W  ALU result.
- zero  out  1  result == 0.
- hi  out  W  HI register.
- lo  out  W  LO register.
- branch_taken  out  1  Branch_final.
- ovf  out  1  signed overflow (optional feature).

Behaviour:
- AluOp decode: 0000 ADD; 0001 SUB; 0011 AND; 0100 OR; 0101 XOR; 0110 SLT; 0111 PASSB; 0010 R-type (funct decode); any other value ADD.
- Funct decode, giving alu_ctl: 100000/100001 ADD 0010; 100010/100011 SUB 0110; 100100 AND 0000; 100101 OR 0001; 100110 XOR 0011; 100111 NOR 1100; 101010 SLT 0111; 101011 SLTU 1000; 010000 MFHI 1101; 010010 MFLO 1110.
- Shift functs, with shift=1: 000000 SLL 0100; 000010 SRL 0101; 000011 SRA 1001.
- Multiply functs, with hilo_enable=1: 011000 MULT 1010; 011001 MULTU 1011.
- Any other funct: ADD, both flags 0. Flags are 0 for every non-R-type AluOp.
- AND, OR, XOR, NOR are bitwise.
- ADD and SUB are modulo 2^W.
- SLT gives 1 if signed a<b, else 0. SLTU gives 1 if unsigned a<b, else 0.
- SLL gives a<<b[4:0]. SRL gives a>>b[4:0] logical. SRA gives a>>>b[4:0] arithmetic. Bits b[W-1:5] are ignored.
- PASSB (1111) gives b. MFHI gives hi; MFLO gives lo.
- MULT and MULTU: result = low W bits of the product.
- Registered HI/LO: on a rising clk with en=1 and alu_ctl MULT (signed) or MULTU (unsigned), {hi,lo} <= 2W-bit product of a*b. Otherwise hi and lo hold.
- HI/LO read-after-write: MFHI/MFLO in the cycle right after a multiply see the new value (registered, no bypass). The MFHI/MFLO result comes from the current register contents.
- Reset: rst=0 clears hi and lo to 0 immediately. The clear overrides a simultaneous multiply. All combinational outputs follow their inputs during reset.
- Branch compare: eq = (br_a==br_b) and gt = (br_a>br_b), both unsigned.
- Branch conditions by branch_op: 000 eq (beq); 001 !eq (bne); 010 gt; 011 gt|eq; 100 !gt&!eq (lt); 101 !gt (le); 110 and 111 never taken.
- branch_taken = branch & condition. branch=0 forces 0 regardless of operands.
- Latency: every output except hi/lo is combinational in the same cycle.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- When defined: ovf=1 for ADD when a and b have equal sign and the result sign differs. ovf=1 for SUB when a and b differ in sign and the result sign differs from a. ovf=0 for all other codes.
- Overflow never blocks result or HI/LO updates.
- When undefined: ovf tied to 0 and no overflow logic is synthesized. The port list is identical in both builds.

Test Plan:
- R-type decode: alu_op=0010, funct=100010, a=5, b=7 -> alu_ctl=0110, result=0xFFFFFFFE, zero=0, shift=0, hilo_enable=0.
- Shift and compare: funct=000011, a=0x80000000, b=4 -> shift=1, result=0xF8000000. Funct=101010, a=-1, b=1 -> result=1. Funct=101011 with the same operands -> result=0.
- Multiply and move: MULT with a=-2, b=3, en=1, one clock -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. Next cycle MFLO gives result=0xFFFFFFFA. Repeating MULTU with en=0 leaves hi/lo unchanged.
- Reset: after a multiply leaves hi/lo nonzero, pulse rst=0 between clock edges -> hi=lo=0 immediately, without waiting for a clock.
- Branch: br_a=br_b=9 -> branch_op 000 taken, 001 not taken, 011 taken, 101 taken. br_a=3, br_b=9 -> 100 taken. Same inputs with branch=0 -> never taken. branch_op=110 -> never taken.
- Overflow (macro defined): ADD 0x7FFFFFFF+1 -> result=0x80000000, ovf=1. SUB 0x80000000-1 -> ovf=1. With the macro undefined, the same cases give ovf=0.
